seq_alu: RTL and testbench

Sequential arithmetic responder for the first_cpu datapath. It accepts one operation per transaction (opcode plus two operands) over a valid/ready request channel. It computes add, sub, mul or div, and returns the result over a valid/ready response channel. Divide is iterative (restoring, one bit per cycle); the other operations complete in one cycle.

---
 rtl/seq_alu_pkg.sv | 20 ++
 rtl/seq_alu_if.sv | 26 ++
 rtl/seq_alu_divider.sv | 83 ++++++++
 rtl/seq_alu.sv | 122 ++++++++++++
 tb/tb_seq_alu.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the seq_alu sequential arithmetic responder.
package seq_alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DIV,
    DONE
  } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response valid-ready channel bundle between a requester (master) and seq_alu (slave).
interface seq_alu_if
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       opcode;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output in_valid, opcode, operand1, operand2, out_ready,
    input  in_ready, out_valid, result, err
  );

  modport slave (
    input  in_valid, opcode, operand1, operand2, out_ready,
    output in_ready, out_valid, result, err
  );
endinterface

// File: rtl/seq_alu_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; built only when SEQ_ALU_DIV_EN is defined.
`ifdef SEQ_ALU_DIV_EN
module seq_alu_divider
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  // quo_q starts as the dividend: its MSB feeds the remainder while quotient bits enter at the LSB.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    trial  = {rem_q, quo_q[WIDTH-1]};
    diff   = trial[WIDTH-1:0] - dvs_q;
    if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
      cnt_d  = CW'(WIDTH - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = diff;
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;
endmodule
`endif

// File: rtl/seq_alu.sv
// Sequential add/sub/mul/div responder with valid-ready request and response channels.
// Define SEQ_ALU_DIV_EN to build the iterative divider; otherwise div reports err with result 0.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic     clk,
  input  logic     reset,
  seq_alu_if.slave bus
);
  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             in_ready;
  logic             accept;
  logic             go_div;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quotient;

  assign in_ready = (state_q == IDLE) && !reset && !div_busy;
  assign accept   = bus.in_valid && in_ready;

`ifdef SEQ_ALU_DIV_EN
  // Divide-by-zero never enters the divider; it resolves in EXEC like a single-cycle op.
  assign go_div = accept && (bus.opcode == OP_DIV) && (bus.operand2 != '0);

  seq_alu_divider #(
    .WIDTH (WIDTH)
  ) u_divider (
    .clk      (clk),
    .reset    (reset),
    .start    (go_div),
    .dividend (bus.operand1),
    .divisor  (bus.operand2),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );
`else
  assign go_div       = 1'b0;
  assign div_busy     = 1'b0;
  assign div_done     = 1'b0;
  assign div_quotient = '0;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = op_e'(bus.opcode);
          a_d     = bus.operand1;
          b_d     = bus.operand2;
          state_d = go_div ? DIV : EXEC;
        end
      end
      EXEC: begin
        err_d = 1'b0;
        unique case (op_q)
          OP_ADD: result_d = a_q + b_q;
          OP_SUB: result_d = a_q - b_q;
          OP_MUL: result_d = a_q * b_q;
          default: begin
`ifdef SEQ_ALU_DIV_EN
            result_d = '1;
`else
            result_d = '0;
`endif
            err_d = 1'b1;
          end
        endcase
        state_d = DONE;
      end
      DIV: begin
        if (div_done) begin
          result_d = div_quotient;
          err_d    = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: an arithmetic/latency model checked every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_seq_alu;
  localparam int W   = 8;
  localparam int MOD = 1 << W;

`ifdef SEQ_ALU_DIV_EN
  localparam int DIV_R = 8;
  localparam int DIV_E = 0;
  localparam int DIV_L = W + 1;
  localparam int DZ_R  = 255;
  localparam int D2_R  = 255;
  localparam int D2_E  = 0;
  localparam int D2_L  = W + 1;
`else
  localparam int DIV_R = 0;
  localparam int DIV_E = 1;
  localparam int DIV_L = 1;
  localparam int DZ_R  = 0;
  localparam int D2_R  = 0;
  localparam int D2_E  = 1;
  localparam int D2_L  = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   checking = 1'b0;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result, error flag and cycles from accept to out_valid, straight from the arithmetic rules.
  function automatic void model(input int op, input int a, input int b,
                                output int r, output int e, output int lat);
    e   = 0;
    lat = 1;
    case (op)
      0: r = (a + b) % MOD;
      1: r = (a - b + MOD) % MOD;
      2: r = (a * b) % MOD;
      default: begin
`ifdef SEQ_ALU_DIV_EN
        if (b == 0) begin
          r = MOD - 1;
          e = 1;
        end else begin
          r   = a / b;
          lat = W + 1;
        end
`else
        r = 0;
        e = 1;
`endif
      end
    endcase
  endfunction

  bit m_busy = 1'b0;
  int m_cnt = 0;
  int m_res = 0;
  int m_err = 0;
  int mr, me, ml;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (bus.in_valid) begin
        model(int'(bus.opcode), int'(bus.operand1), int'(bus.operand2), mr, me, ml);
        m_busy <= 1'b1;
        m_res  <= mr;
        m_err  <= me;
        m_cnt  <= ml;
      end
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end else if (bus.out_ready) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("mon_in_ready", int'(bus.in_ready), int'(!m_busy && !reset));
      chk("mon_out_valid", int'(bus.out_valid), int'(m_busy && m_cnt == 0));
      if (m_busy && m_cnt == 0) begin
        chk("mon_result", int'(bus.result), m_res);
        chk("mon_err", int'(bus.err), m_err);
      end
    end
  end

  // Called and returns at posedge+1; holds out_ready low for `hold` cycles while offering junk requests.
  task automatic run_op(input string name, input int op, input int a, input int b,
                        input int er, input int ee, input int el, input int hold);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_ready_wait"}, int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.opcode   = 2'(op);
    bus.operand1 = 8'(a);
    bus.operand2 = 8'(b);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.opcode   = 2'($urandom);
    bus.operand1 = 8'($urandom);
    bus.operand2 = 8'($urandom);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, n, el);
    chk({name, "_result"}, int'(bus.result), er);
    chk({name, "_err"}, int'(bus.err), ee);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.opcode   = 2'($urandom);
      bus.operand1 = 8'($urandom);
      bus.operand2 = 8'($urandom);
      @(posedge clk); #1;
      chk({name, "_hold_valid"}, int'(bus.out_valid), 1);
      chk({name, "_hold_result"}, int'(bus.result), er);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({name, "_ready_after"}, int'(bus.in_ready), 1);
    chk({name, "_valid_after"}, int'(bus.out_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pr, pe, pl, seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.opcode    = '0;
    bus.operand1  = '0;
    bus.operand2  = '0;

    model(1, 2, 15, pr, pe, pl);
    chk("model_sub_wrap", pr, 243);
    model(2, 20, 20, pr, pe, pl);
    chk("model_mul_trunc", pr, 144);
    model(3, 16, 2, pr, pe, pl);
    chk("model_div", pr, DIV_R);
    chk("model_div_lat", pl, DIV_L);

    @(posedge clk); #1;
    checking = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_err", int'(bus.err), 0);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;

    run_op("add",       0,  40,  5,  45,   0,     1,     0);
    run_op("sub",       1,  15,  2,  13,   0,     1,     0);
    run_op("sub_wrap",  1,   2, 15, 243,   0,     1,     0);
    run_op("mul",       2,   4,  5,  20,   0,     1,     0);
    run_op("mul_trunc", 2,  20, 20, 144,   0,     1,     0);
    run_op("div",       3,  16,  2, DIV_R, DIV_E, DIV_L, 0);
    run_op("div_zero",  3,   7,  0, DZ_R,  1,     1,     0);
    run_op("div_max",   3, 255,  1, D2_R,  D2_E,  D2_L,  0);
    run_op("add_bp",    0, 200, 100, 44,   0,     1,     5);
    run_op("mul_bp",    2, 255, 255,  1,   0,     1,     2);

    bus.in_valid = 1'b1;
    bus.opcode   = 2'd3;
    bus.operand1 = 8'd200;
    bus.operand2 = 8'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", int'(bus.out_valid), 0);
    chk("abort_ready_in_reset", int'(bus.in_ready), 0);
    chk("abort_result", int'(bus.result), 0);
    reset = 1'b0;
    #1;
    chk("abort_ready_release", int'(bus.in_ready), 1);
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    chk("abort_no_response", seen, 0);
    run_op("after_abort", 0, 1, 1, 2, 0, 1, 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
